mac_unit: RTL
=============

MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are even and >= 8.
REQ-002 SHALL have parameter STEP, default 2, multiplier bits retired per cycle; legal values are 1, 2 or 4, and STEP must divide WIDTH.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  request a new operation.
REQ-006 SHALL have port annul_i  input  1  cancel the in-flight operation.
REQ-007 SHALL have port signed_i  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 SHALL have port op_i  input  2  00 MULT, 01 MADD, 10 MSUB, 11 reserved (treated as MULT).
REQ-009 SHALL have port opdata1_i  input  WIDTH  multiplicand.
REQ-010 SHALL have port opdata2_i  input  WIDTH  multiplier.
REQ-011 SHALL have port acc_i  input  2*WIDTH  accumulator operand {HI,LO}.
REQ-012 SHALL have port result_o  output  2*WIDTH  final {HI,LO} result.
REQ-013 SHALL have port ready_o  output  1  result_o valid, one-cycle pulse.
REQ-014 SHALL have port busy_o  output  1  operation in flight; the pipeline uses it as a stall request.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, ACC, DONE.
REQ-016 In IDLE, start_i=1 and annul_i=0 SHALL:
- register opdata1_i, opdata2_i, acc_i, op_i and signed_i;
- move to CALC.
REQ-017 start_i SHALL be ignored in every state other than IDLE.
REQ-018 When signed_i=1, each negative operand SHALL be replaced by its magnitude (~x+1) at capture, and the product sign SHALL be recorded as the XOR of the operand sign bits.
- The magnitude of the most negative value is 2^(WIDTH-1), held unsigned.
REQ-019 CALC SHALL last exactly N=WIDTH/STEP cycles; each cycle SHALL:
- add (multiplicand * low STEP bits of the remaining multiplier), shifted by STEP*i, into a 2*WIDTH partial product;
- shift the multiplier right by STEP.
REQ-020 There SHALL be no early termination: latency is fixed regardless of operand values, including zero.
REQ-021 ACC SHALL last one cycle; in it:
- the product SHALL be negated if the recorded product sign is 1;
- the result SHALL be P for MULT, acc+P for MADD, acc-P for MSUB;
- all arithmetic is modulo 2^(2*WIDTH), with no overflow flag.
REQ-022 DONE SHALL last one cycle with ready_o=1 and result_o equal to the final value, then return to IDLE.
REQ-023 result_o SHALL be 0 in every cycle in which ready_o=0.
REQ-024 Latency from the start_i accept edge to the ready_o cycle SHALL be N+2 cycles (18 for the default parameters).
REQ-025 busy_o SHALL be 1 in CALC and ACC and 0 in IDLE and DONE.
REQ-026 A new start_i SHALL be accepted in the IDLE cycle immediately following DONE.
REQ-027 annul_i=1 in CALC, ACC or DONE SHALL:
- force IDLE on the next edge;
- prevent any ready_o pulse for that operation;
- take priority over the DONE pulse.
REQ-028 annul_i=1 together with start_i=1 in IDLE SHALL leave the FSM in IDLE, with the start dropped.
REQ-029 Internal operand and partial-product registers SHALL NOT affect the outputs outside DONE.

Reset
REQ-030 rst=1 at a clock edge SHALL, in any state including mid-CALC:
- force IDLE;
- clear the partial product, the step counter and all captured operands;
- drive ready_o=0, busy_o=0, result_o=0.
REQ-031 rst SHALL take priority over start_i and annul_i.
REQ-032 The first start_i accepted after reset release SHALL behave identically to one accepted from power-up.

Verification (WIDTH=32, STEP=2)
REQ-033 Unsigned MULT, 0xFFFFFFFF x 0xFFFFFFFF -> ready_o pulses 18 cycles after accept, result_o=0xFFFFFFFE_00000001, busy_o=1 for exactly 17 cycles.
REQ-034 Signed MULT, -3 x 5 -> result_o=0xFFFFFFFF_FFFFFFF1; signed 0x80000000 x 0x80000000 -> 0x40000000_00000000.
REQ-035 Signed MADD, acc=0x00000000_00000010, 2 x -4 -> result_o=0x00000000_00000008; unsigned MSUB, acc=0, 1 x 1 -> result_o=0xFFFFFFFF_FFFFFFFF (wrap).
REQ-036 annul_i on the 5th CALC cycle -> busy_o=0 on the next cycle, no ready_o pulse; a start on the following cycle with 7 x 6 -> 0x2A after 18 cycles.
REQ-037 rst asserted mid-CALC -> all outputs 0 on the next cycle; a start_i held during busy is ignored, and the original result is unaffected.
REQ-038 Back-to-back operations: a second start in the IDLE cycle after DONE -> its ready_o arrives 18 cycles later, and result_o=0 in the cycles between the two pulses.

Source files
------------

// File: rtl/mac_unit.sv
// Multi-cycle multiply / multiply-accumulate unit.
// Radix-2^STEP shift-add multiplier on operand magnitudes, followed by a
// single sign-fix/accumulate cycle and a one-cycle result pulse.
module mac_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 annul_i,
  input  logic                 signed_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] OP_MADD = 2'b01;
  localparam logic [1:0] OP_MSUB = 2'b10;

  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;

  state_t               state_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [1:0]           op_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 busy_q;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   step_term;
  logic [2*WIDTH-1:0]   prod_d;
  logic [2*WIDTH-1:0]   prod_s;
  logic [2*WIDTH-1:0]   final_d;

  // Operand magnitudes at capture; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_neg = signed_i & opdata1_i[WIDTH-1];
    b_neg = signed_i & opdata2_i[WIDTH-1];
    a_mag = a_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    b_mag = b_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
  end

  // One radix step: multiplicand (pre-shifted by STEP*i) times the low STEP multiplier bits.
  always_comb begin
    step_term = '0;
    for (int unsigned b = 0; b < STEP; b++) begin
      if (mplier_q[b]) step_term = step_term + (mcand_q << b);
    end
    prod_d = prod_q + step_term;
  end

  // Sign fix-up and accumulate, all modulo 2^(2*WIDTH).
  always_comb begin
    prod_s = neg_q ? (~prod_q + (2*WIDTH)'(1)) : prod_q;
    case (op_q)
      OP_MADD: final_d = acc_q + prod_s;
      OP_MSUB: final_d = acc_q - prod_s;
      default: final_d = prod_s;
    endcase
  end

  // Control FSM with registered ready/busy/result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          busy_q   <= 1'b0;
          if (start_i && !annul_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_mag};
            mplier_q <= b_mag;
            acc_q    <= acc_i;
            op_q     <= op_i;
            neg_q    <= a_neg ^ b_neg;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (annul_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << STEP;
            mplier_q <= mplier_q >> STEP;
            cnt_q    <= cnt_q + CW'(1);
            if (cnt_q == LAST) state_q <= ACC;
          end
        end
        ACC: begin
          busy_q <= 1'b0;
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            result_q <= final_d;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          state_q  <= IDLE;
        end
        default: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // The DONE pulse is already registered when annul_i arrives in DONE, so it is
  // masked here to let the cancel win within that same cycle.
  assign ready_o  = ready_q & ~annul_i;
  assign result_o = ready_o ? result_q : '0;
  assign busy_o   = busy_q;

endmodule
